// File: rtl/cordic_iter_ctrl.sv
// rtl/cordic_iter_ctrl.sv - iterative CORDIC sequencer around an external combinational stage
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready        operand handshake
//   x_in, y_in, z_in          signed operand words
//   x_cur, y_cur, z_cur       registered working state fed to the external stage
//   stage_i                   iteration index fed to the external stage
//   x_nxt, y_nxt, z_nxt       external stage result for the current state/index
//   out_valid, out_ready      result handshake
//   x_out, y_out, z_out       result words (mirror of x_cur/y_cur/z_cur)
//   busy                      high while an operation is running or waiting to be taken
//   op_count                  completed-operation counter, wraps at 16 bits
module cordic_iter_ctrl #(
  parameter int WORD_LENGTH = 21,
  parameter int ITERATIONS  = 16,
  parameter int IDX_W       = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] x_in,
  input  logic [WORD_LENGTH-1:0] y_in,
  input  logic [WORD_LENGTH-1:0] z_in,
  output logic [WORD_LENGTH-1:0] x_cur,
  output logic [WORD_LENGTH-1:0] y_cur,
  output logic [WORD_LENGTH-1:0] z_cur,
  output logic [IDX_W-1:0]       stage_i,
  input  logic [WORD_LENGTH-1:0] x_nxt,
  input  logic [WORD_LENGTH-1:0] y_nxt,
  input  logic [WORD_LENGTH-1:0] z_nxt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] x_out,
  output logic [WORD_LENGTH-1:0] y_out,
  output logic [WORD_LENGTH-1:0] z_out,
  output logic                   busy,
  output logic [15:0]            op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERATIONS - 1);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   last_stage;
  logic   consume;

  // Control: ready in IDLE, or in DONE when the consumer takes the result
  // on the same edge, which lets a new operand follow with no bubble.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    last_stage = (stage_i == LAST_IDX);
    consume    = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_stage) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
        consume   = out_ready;
        if (out_ready) begin
          state_nxt = in_valid ? RUN : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    accept = in_valid && in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Working registers: an accept always wins, so a DONE->RUN handoff
  // overwrites the consumed result with the new operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cur   <= '0;
      y_cur   <= '0;
      z_cur   <= '0;
      stage_i <= '0;
    end else if (accept) begin
      x_cur   <= x_in;
      y_cur   <= y_in;
      z_cur   <= z_in;
      stage_i <= '0;
    end else if (state == RUN) begin
      x_cur <= x_nxt;
      y_cur <= y_nxt;
      z_cur <= z_nxt;
      // The index stays on the last value so it reads ITERATIONS-1 in DONE.
      if (!last_stage) begin
        stage_i <= stage_i + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= 16'h0000;
    end else if (consume) begin
      op_count <= op_count + 16'h0001;
    end
  end

  assign x_out = x_cur;
  assign y_out = y_cur;
  assign z_out = z_cur;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb/tb_cordic_iter_ctrl.sv - directed table-driven bench for cordic_iter_ctrl
module tb_cordic_iter_ctrl;

  localparam int WL = 21;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance, ITERATIONS=16
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WL-1:0] x_in = '0, y_in = '0, z_in = '0;
  logic [WL-1:0] x_cur, y_cur, z_cur;
  logic [4:0]    stage_i;
  logic [WL-1:0] x_nxt, y_nxt, z_nxt;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WL-1:0] x_out, y_out, z_out;
  logic          busy;
  logic [15:0]   op_count;

  assign x_nxt = x_cur + WL'(1);
  assign y_nxt = y_cur - WL'(2);
  assign z_nxt = z_cur + WL'(stage_i);

  cordic_iter_ctrl #(.WORD_LENGTH(WL), .ITERATIONS(16), .IDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .x_cur(x_cur), .y_cur(y_cur), .z_cur(z_cur),
    .stage_i(stage_i),
    .x_nxt(x_nxt), .y_nxt(y_nxt), .z_nxt(z_nxt),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .busy(busy), .op_count(op_count)
  );

  // second instance, ITERATIONS=2
  logic          b_in_valid = 1'b0;
  logic          b_in_ready;
  logic [WL-1:0] b_x_in = '0, b_y_in = '0, b_z_in = '0;
  logic [WL-1:0] b_x_cur, b_y_cur, b_z_cur;
  logic [0:0]    b_stage_i;
  logic [WL-1:0] b_x_nxt, b_y_nxt, b_z_nxt;
  logic          b_out_valid;
  logic          b_out_ready = 1'b0;
  logic [WL-1:0] b_x_out, b_y_out, b_z_out;
  logic          b_busy;
  logic [15:0]   b_op_count;

  assign b_x_nxt = b_x_cur + WL'(1);
  assign b_y_nxt = b_y_cur - WL'(2);
  assign b_z_nxt = b_z_cur + WL'(b_stage_i);

  cordic_iter_ctrl #(.WORD_LENGTH(WL), .ITERATIONS(2), .IDX_W(1)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x_in(b_x_in), .y_in(b_y_in), .z_in(b_z_in),
    .x_cur(b_x_cur), .y_cur(b_y_cur), .z_cur(b_z_cur),
    .stage_i(b_stage_i),
    .x_nxt(b_x_nxt), .y_nxt(b_y_nxt), .z_nxt(b_z_nxt),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .x_out(b_x_out), .y_out(b_y_out), .z_out(b_z_out),
    .busy(b_busy), .op_count(b_op_count)
  );

  typedef struct {
    int x, y, z;
    int ex, ey, ez;
  } vec_t;

  vec_t tbl[4];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input logic [WL-1:0] v);
    return int'($signed(v));
  endfunction

  // Accept one operand from IDLE, run it to DONE, optionally hold the
  // result under backpressure, then hand it off and return to IDLE.
  task automatic run_op(input vec_t v, input bit bp);
    int lat;
    int rdy_run;
    int bad;
    x_in = WL'(v.x); y_in = WL'(v.y); z_in = WL'(v.z);
    in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_idle", int'(in_ready), 1);
    @(posedge clk); #1;
    chk("stage_after_accept", int'(stage_i), 0);
    chk("x_loaded", sx(x_cur), v.x);
    // junk offered during RUN must be ignored
    x_in = WL'(12345); y_in = WL'(-777); z_in = WL'(999);
    lat = 0; rdy_run = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_run++;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 16);
    chk("in_ready_in_run", rdy_run, 0);
    chk("x_out", sx(x_out), v.ex);
    chk("y_out", sx(y_out), v.ey);
    chk("z_out", sx(z_out), v.ez);
    chk("stage_held", int'(stage_i), 15);
    chk("busy_done", int'(busy), 1);
    if (bp) begin
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || sx(x_out) != v.ex || sx(y_out) != v.ey || sx(z_out) != v.ez)
          bad++;
      end
      chk("backpressure_stable", bad, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) & 16'hffff;
    chk("out_valid_after_take", int'(out_valid), 0);
    chk("busy_idle", int'(busy), 0);
    chk("op_count", int'(op_count), exp_cnt);
    chk("x_retained", sx(x_out), v.ex);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    tbl[0] = '{x: 5,        y: 100,      z: 0,    ex: 21,       ey: 68,      ez: 120};
    tbl[1] = '{x: 0,        y: 0,        z: 0,    ex: 16,       ey: -32,     ez: 120};
    tbl[2] = '{x: -10,      y: 7,        z: -120, ex: 6,        ey: -25,     ez: 0};
    tbl[3] = '{x: 1048575,  y: -1048576, z: 1000, ex: -1048561, ey: 1048544, ez: 1120};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_x", sx(x_cur), 0);
    chk("rst_stage", int'(stage_i), 0);
    chk("rst_op_count", int'(op_count), 0);
    rst = 1'b0;

    // reset mid-RUN at stage 7: first accept is on the first edge after release
    x_in = WL'(5); y_in = WL'(100); z_in = WL'(0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("first_edge_accept", int'(busy), 1);
    lat = 0;
    while (stage_i != 5'd7 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("reached_stage7", int'(stage_i), 7);
    rst = 1'b1;
    #1;
    chk("async_rst_x", sx(x_cur), 0);
    chk("async_rst_y", sx(y_cur), 0);
    chk("async_rst_z", sx(z_cur), 0);
    chk("async_rst_stage", int'(stage_i), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_ready", int'(in_ready), 1);
    chk("async_rst_count", int'(op_count), 0);
    #2 rst = 1'b0;

    // table: first op with backpressure, rest plain
    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i], i == 0);
    end

    // back-to-back: second operand accepted on the edge the first result is taken
    x_in = WL'(tbl[1].x); y_in = WL'(tbl[1].y); z_in = WL'(tbl[1].z);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    x_in = WL'(tbl[2].x); y_in = WL'(tbl[2].y); z_in = WL'(tbl[2].z);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_latency_a", lat, 16);
    chk("b2b_x_a", sx(x_out), tbl[1].ex);
    chk("b2b_ready_done", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_cnt = (exp_cnt + 1) & 16'hffff;
    chk("b2b_handoff_valid", int'(out_valid), 0);
    chk("b2b_handoff_stage", int'(stage_i), 0);
    chk("b2b_handoff_x", sx(x_cur), tbl[2].x);
    chk("b2b_count_a", int'(op_count), exp_cnt);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_latency_b", lat, 16);
    chk("b2b_x_b", sx(x_out), tbl[2].ex);
    chk("b2b_y_b", sx(y_out), tbl[2].ey);
    chk("b2b_z_b", sx(z_out), tbl[2].ez);
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) & 16'hffff;
    chk("b2b_count_b", int'(op_count), exp_cnt);
    chk("b2b_idle", int'(busy), 0);

    // counter wrap: preload to 0xFFFF, one more completion wraps to 0
    force dut.op_count = 16'hffff;
    #1 release dut.op_count;
    exp_cnt = 16'hffff;
    run_op(tbl[0], 1'b0);
    chk("wrap_zero", int'(op_count), 0);

    // ITERATIONS=2 instance
    b_x_in = WL'(0); b_y_in = WL'(0); b_z_in = WL'(0);
    b_in_valid = 1'b1;
    chk("b_ready_idle", int'(b_in_ready), 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk("b_stage0", int'(b_stage_i), 0);
    chk("b_valid_e0", int'(b_out_valid), 0);
    @(posedge clk); #1;
    chk("b_stage1", int'(b_stage_i), 1);
    chk("b_valid_e1", int'(b_out_valid), 0);
    @(posedge clk); #1;
    chk("b_valid_e2", int'(b_out_valid), 1);
    chk("b_x_out", sx(b_x_out), 2);
    chk("b_y_out", sx(b_y_out), -4);
    chk("b_z_out", sx(b_z_out), 1);
    chk("b_stage_held", int'(b_stage_i), 1);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk("b_op_count", int'(b_op_count), 1);
    chk("b_idle", int'(b_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
